// File: rtl/siso_arb_pkg.sv
// Purpose : shared types and width helpers for the serial channel arbiter.
// Latency : n/a (package only).
// Backpressure: n/a.
// Contents: FSM state encoding, clog2, counter-width helpers.
package siso_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_GAP    = 2'd3
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return r;
  endfunction

  // Width of a counter that runs 0..n-1; never narrower than one bit so that
  // degenerate configurations (n = 0 or 1) still elaborate.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/siso_shift_core.sv
// Purpose : N-bit parallel-load, left-shift register; MSB drives the serial line.
// Latency : word visible on msb the cycle after load.
// Backpressure: none; load/shift_en are sampled every cycle, load has priority.
// Ports   : clk, rst_n (async active-low), load, shift_en, word[N-1:0] in; msb out.
module siso_shift_core #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         shift_en,
  input  logic [N-1:0] word,
  output logic         msb
);

  logic [N-1:0] sr_q;
  logic [N-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = word;
    end else if (shift_en) begin
      // Zero fill: after N shifts the register is clear again.
      sr_d = {sr_q[N-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign msb = sr_q[N-1];

endmodule

// File: rtl/siso_channel_arbiter.sv
// Purpose : round-robin share of one serial channel among NREQ word requesters; MSB-first framed bursts.
// Latency : first frame bit one cycle after the valid/ready handshake; frame = N bits (+1 parity).
// Backpressure: req_ready only in IDLE, one-hot to the round-robin winner; held-off requesters keep valid.
// Ports   : clk, rst_n, req_valid[NREQ], req_data[NREQ*N] in;
//           req_ready[NREQ], serial_out, frame, busy, grant_id out.
// Option  : SISO_ARB_PARITY_EN adds an even-parity bit after the data bits.
module siso_channel_arbiter
  import siso_arb_pkg::*;
#(
  parameter int N          = 4,
  parameter int NREQ       = 2,
  parameter int GAP_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*N-1:0]      req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic                   serial_out,
  output logic                   frame,
  output logic                   busy,
  output logic [clog2(NREQ)-1:0] grant_id
);

  localparam int PTR_W    = clog2(NREQ);
  localparam int BIT_W    = clog2(N);
  localparam int GAP_W    = cnt_w(GAP_CYCLES);
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   grant_q, grant_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;

  logic [PTR_W-1:0]   winner;
  logic [PTR_W-1:0]   cand;
  logic               any_vld;
  logic [N-1:0]       sel_word;
  logic               hs;
  logic               load;
  logic               shift_en;
  logic               msb;

  // Round-robin search starting at ptr_q, wrapping at NREQ.
  always_comb begin
    winner  = '0;
    cand    = '0;
    any_vld = 1'b0;
    for (int off = 0; off < NREQ; off++) begin
      cand = PTR_W'((int'(ptr_q) + off) % NREQ);
      if (!any_vld && req_valid[cand]) begin
        any_vld = 1'b1;
        winner  = cand;
      end
    end
  end

  assign sel_word = req_data[int'(winner)*N +: N];

  // rst_n gating keeps ready low while reset is held, even though the
  // registered state already reads IDLE.
  assign req_ready = (rst_n && state_q == ST_IDLE && any_vld) ? (NREQ'(1) << winner) : '0;
  assign hs        = |req_ready;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    load      = 1'b0;
    shift_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hs) begin
          load      = 1'b1;
          grant_d   = winner;
          ptr_d     = (winner == PTR_W'(NREQ - 1)) ? '0 : winner + 1'b1;
          bit_cnt_d = '0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shift_en = 1'b1;
        if (bit_cnt_q == BIT_W'(N - 1)) begin
          bit_cnt_d = '0;
`ifdef SISO_ARB_PARITY_EN
          state_d   = ST_PARITY;
`else
          state_d   = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
`endif
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
      ST_PARITY: begin
        state_d = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_LAST)) begin
          gap_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      grant_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  siso_shift_core #(.N(N)) u_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .shift_en (shift_en),
    .word     (sel_word),
    .msb      (msb)
  );

`ifdef SISO_ARB_PARITY_EN
  logic par_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else if (hs) begin
      par_q <= ^sel_word;
    end
  end
  assign serial_out = (state_q == ST_SHIFT) ? msb : ((state_q == ST_PARITY) ? par_q : 1'b0);
`else
  assign serial_out = (state_q == ST_SHIFT) ? msb : 1'b0;
`endif

  assign frame    = (state_q == ST_SHIFT) || (state_q == ST_PARITY);
  assign busy     = (state_q != ST_IDLE);
  assign grant_id = grant_q;

endmodule
